seven_seg_scan: RTL
===================

# seven_seg_scan

Upstream driver for the single-digit seven-segment decoder on the Basys3 four-digit display. It accepts a binary value through a load handshake and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes those digits onto the shared cathode bus. Each refresh slot presents one 4-bit BCD `digit` to the decoder and drives the matching active-low anode; leading-zero blanking is optional.

## Interface
Parameters:
- `REFRESH_DIV`, default 100_000: clock cycles per digit slot (1 kHz per digit at 100 MHz). Minimum legal value is 2.

Ports:
- Clock and reset: one clock (`clk`); reset (`rst_n`) is asynchronous and active-low.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `value`  in  14  unsigned binary to display; sampled only on an accepted load.
- `load`  in  1  load request; accepted only when `busy`=0.
- `blank_lz`  in  1  leading-zero blanking enable; level, sampled every cycle.
- `busy`  out  1  conversion in progress; loads are ignored while high.
- `digit`  out  4  BCD digit for the current slot, always 0–9; feeds the decoder `binary` input.
- `an`  out  4  anodes, active-low, one-hot-low; bit i is digit i, and digit 0 is the least significant.

## Operation
- States:
  - IDLE: waiting for a load.
  - CONVERT: shifting; shift counter runs 0..13.
  - COMMIT: copying the result to the display registers.
- IDLE → CONVERT when `load`=1:
  - Capture `min(value, 9999)` into the 14-bit shift register. Values 10000–16383 saturate to 9999.
  - Clear the 16-bit BCD accumulator and clear the shift counter.
  - Set `busy`=1.
- CONVERT, each cycle:
  - For every BCD nibble ≥5, add 3 to it.
  - Shift {BCD, binary} left by one.
  - Increment the shift counter.
  - After the 14th shift, go to COMMIT.
- COMMIT:
  - Copy the BCD accumulator into the display register `disp[3:0]` (four nibbles).
  - Set `busy`=0 and return to IDLE.
- `load` in CONVERT or COMMIT is ignored and not queued.
- Display registers change only in COMMIT. During conversion the scanner keeps showing the old value, so digits never tear.
- Scanner (free-running, independent of the conversion FSM):
  - Refresh counter counts 0..REFRESH_DIV-1.
  - At the terminal count it wraps to 0 and the slot index `idx` (2-bit) increments modulo 4 (3→0).
  - `digit` = `disp[idx]`.
  - `an` = ~(4'b0001 << idx), unless the slot is blanked, in which case `an` = 4'b1111.
- Blanking:
  - Slot idx>0 is blanked iff `blank_lz`=1 and `disp[idx]` through `disp[3]` are all 0.
  - Slot 0 is never blanked, so value 0 shows "0".
- `digit`, `an` and `busy` are registered outputs with no combinational path from inputs.

## Timing
- Reset values (asynchronous, immediate):
  - `busy`=0, state IDLE.
  - `disp`=0000 (all digits 0), `idx`=0, refresh counter 0.
  - `digit`=0, `an`=4'b1110.
- Latency, with `load` sampled high at edge k:
  - `busy`=1 after edge k.
  - Shifts occur on edges k+1..k+14.
  - Commit occurs on edge k+15: new `disp` and `busy`=0 are visible after it.
  - `busy` is high for exactly 15 cycles.
  - The next load can be accepted at edge k+16.
- Scanner outputs (`idx`, `digit`, `an`) update one cycle after the refresh terminal count. Each slot lasts exactly REFRESH_DIV cycles.
- If commit and a slot change land on the same edge, the new slot shows the new `disp` one cycle later. The old value persists for at most one cycle; this is acceptable.
- Reset asserted mid-conversion aborts the conversion. All outputs return to reset values and no partial result is committed.
- A `blank_lz` change takes effect on the next registered output update, one cycle later.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle. Outputs go immediately to `busy`=0, `an`=1110, `digit`=0. After release, with `REFRESH_DIV`=4, `an` cycles 1110, 1101, 1011, 0111 with 4 cycles per slot and `digit`=0 in every slot.
- Load 1234 with `REFRESH_DIV`=4:
  - `busy` is high for exactly 15 cycles.
  - After commit, `digit`/`an` pairs are 4/1110, 3/1101, 2/1011, 1/0111, repeating.
- Saturation: load 14'd12000. The display shows 9,9,9,9 in all slots.
- Blanking: load 7 with `blank_lz`=1. `an` = 1110 with `digit` 7 in slot 0, and `an` = 1111 in slots 1–3. Set `blank_lz`=0: the sequence becomes 7,0,0,0 with all anodes active.
- Load collision: load 42, then pulse `load` with 99 while `busy`=1. Exactly one conversion occurs and the display shows 2,4,0,0. Then load 0 with `blank_lz`=1: only slot 0 is lit, showing 0.
- Reset mid-conversion: load 5678 and assert `rst_n` at cycle 7 of `busy`. All digits are 0 after release, and a following load of 5678 displays 8,7,6,5.

Source files
------------

// File: rtl/seven_seg_scan.sv
// ---------------------------------------------------------------------------
// seven_seg_scan: binary-to-BCD double-dabble converter feeding a 4-digit
// multiplexed seven-segment scanner.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seven_seg_scan #(
   parameter int REFRESH_DIV = 100_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [13:0] value,
   input  logic        load,
   input  logic        blank_lz,
   output logic        busy,
   output logic [3:0]  digit,
   output logic [3:0]  an
);

   localparam int            RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [RW-1:0] TC = RW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   state_t        state;
   logic [13:0]   shreg;
   logic [15:0]   bcd;
   logic [15:0]   bcd_adj;
   logic [3:0]    shift_cnt;
   logic [15:0]   disp;
   logic [RW-1:0] rcnt;
   logic [1:0]    idx;
   logic [3:0]    lz;
   logic          slot_blank;

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 4; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // Conversion FSM; disp only moves in COMMIT so the scanner never tears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         shreg     <= '0;
         bcd       <= '0;
         shift_cnt <= '0;
         disp      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  shreg     <= (value > 14'd9999) ? 14'd9999 : value;
                  bcd       <= '0;
                  shift_cnt <= '0;
                  busy      <= 1'b1;
                  state     <= CONVERT;
               end
            end
            CONVERT: begin
               {bcd, shreg} <= {bcd_adj, shreg} << 1;
               shift_cnt    <= shift_cnt + 4'd1;
               if (shift_cnt == 4'd13)
                  state <= COMMIT;
            end
            COMMIT: begin
               disp  <= bcd;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // lz[i]: digits i..3 are all zero; slot 0 is never blanked.
   always_comb begin
      lz[3]      = (disp[15:12] == 4'd0);
      lz[2]      = lz[3] && (disp[11:8] == 4'd0);
      lz[1]      = lz[2] && (disp[7:4] == 4'd0);
      lz[0]      = 1'b0;
      slot_blank = blank_lz && lz[idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcnt  <= '0;
         idx   <= 2'd0;
         digit <= 4'd0;
         an    <= 4'b1110;
      end else begin
         if (rcnt == TC) begin
            rcnt <= '0;
            idx  <= idx + 2'd1;
         end else begin
            rcnt <= rcnt + RW'(1);
         end
         digit <= disp[{idx, 2'b00} +: 4];
         an    <= slot_blank ? 4'b1111 : ~(4'b0001 << idx);
      end
   end

endmodule

`default_nettype wire
